// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        WR_BYTE,
        ACK_WR,
        RD_BYTE,
        RD_ACK
    } i2c_tgt_state_t;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers plus one history flop on SCL/SDA, producing
// single-cycle SCL edge and START/STOP condition pulses.
module i2c_bus_sync (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_h;
    logic       sda_h;
    logic       scl;

    // An idle bus is high, so everything resets to 1 to avoid phantom edges.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_h  <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], scl_in};
            sda_ff <= {sda_ff[0], sda_in};
            scl_h  <= scl_ff[1];
            sda_h  <= sda_ff[1];
        end
    end

    assign scl      = scl_ff[1];
    assign sda      = sda_ff[1];
    assign scl_rise = scl & ~scl_h;
    assign scl_fall = ~scl & scl_h;

    // SCL must be stably high in both samples; a simultaneous SCL edge is data.
    assign start = scl & scl_h & ~sda & sda_h;
    assign stop  = scl & scl_h & sda & ~sda_h;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-byte register bank, auto-incrementing pointer and a
// local combinational read port.
//
// state    | meaning
// IDLE     | not addressed, waiting for START
// ADDR     | shifting in address + R/W
// ACK_ADDR | acknowledging our address
// WR_BYTE  | receiving pointer or data byte
// ACK_WR   | acknowledging a received byte
// RD_BYTE  | driving a bank byte onto SDA
// RD_ACK   | waiting for master ACK/NACK
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'b1010000
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [2:0] loc_addr,
    output logic [7:0] loc_rdata,
    output logic       busy,
    output logic       wr_stb,
    output logic [2:0] wr_idx
);

    i2c_tgt_state_t state;
    logic [7:0]     bank [8];
    logic [7:0]     shreg;
    logic [2:0]     bit_cnt;
    logic [2:0]     ptr;
    logic           rw;
    logic           first_byte;
    logic           ack_drv;
    logic           sda;
    logic           scl_rise;
    logic           scl_fall;
    logic           start;
    logic           stop;

    i2c_bus_sync u_sync (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign loc_rdata = bank[loc_addr];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            shreg      <= 8'h00;
            bit_cnt    <= 3'd0;
            ptr        <= 3'd0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            ack_drv    <= 1'b0;
            sda_out    <= 1'b1;
            busy       <= 1'b0;
            wr_stb     <= 1'b0;
            wr_idx     <= 3'd0;
            for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
        end else begin
            wr_stb <= 1'b0;
            if (start) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                ack_drv <= 1'b0;
                sda_out <= 1'b1;
            end else if (stop) begin
                state   <= IDLE;
                ack_drv <= 1'b0;
                sda_out <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: if (scl_rise) begin
                        shreg   <= {shreg[6:0], sda};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shreg[6:0] == TARGET_ADDR) begin
                                state      <= ACK_ADDR;
                                rw         <= sda;
                                busy       <= 1'b1;
                                first_byte <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    // First falling edge starts the ACK, the second ends it.
                    ACK_ADDR, ACK_WR: if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_out <= I2C_ACK;
                            ack_drv <= 1'b1;
                        end else begin
                            ack_drv <= 1'b0;
                            bit_cnt <= 3'd0;
                            if (state == ACK_ADDR && rw == I2C_RW_READ) begin
                                state   <= RD_BYTE;
                                sda_out <= bank[ptr][7];
                                shreg   <= {bank[ptr][6:0], 1'b0};
                                ptr     <= ptr + 3'd1;
                            end else begin
                                state   <= WR_BYTE;
                                sda_out <= 1'b1;
                            end
                        end
                    end
                    WR_BYTE: if (scl_rise) begin
                        shreg   <= {shreg[6:0], sda};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ACK_WR;
                            if (first_byte) begin
                                first_byte <= 1'b0;
                                ptr        <= {shreg[1:0], sda};
                            end else begin
                                bank[ptr] <= {shreg[6:0], sda};
                                wr_stb    <= 1'b1;
                                wr_idx    <= ptr;
                                ptr       <= ptr + 3'd1;
                            end
                        end
                    end
                    RD_BYTE: if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_out <= 1'b1;
                            state   <= RD_ACK;
                            ack_drv <= 1'b0;
                        end else begin
                            sda_out <= shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    // ack_drv here records a master ACK awaiting the next falling edge.
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda == I2C_NACK) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                ack_drv <= 1'b1;
                            end
                        end else if (scl_fall && ack_drv) begin
                            ack_drv <= 1'b0;
                            state   <= RD_BYTE;
                            bit_cnt <= 3'd0;
                            sda_out <= bank[ptr][7];
                            shreg   <= {bank[ptr][6:0], 1'b0};
                            ptr     <= ptr + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-level bench for i2c_target_regs: a bit-banged master feeds a scoreboard
// of expected ACK/read bytes and expected bank writes.
module tb_i2c_target_regs;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       scl_in = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_in;
    logic       sda_out;
    logic [2:0] loc_addr = 3'd0;
    logic [7:0] loc_rdata;
    logic       busy;
    logic       wr_stb;
    logic [2:0] wr_idx;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_val[$];
    string      exp_name[$];
    logic [7:0] obs_val[$];
    logic [2:0] exp_wr_idx[$];
    logic [7:0] exp_wr_data[$];

    assign sda_in = sda_drv & sda_out;

    i2c_target_regs dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_out   (sda_out),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata),
        .busy      (busy),
        .wr_stb    (wr_stb),
        .wr_idx    (wr_idx)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic bit_slot(input logic v, output logic o);
        sda_drv = v;
        wt(4);
        scl_in = 1'b1;
        wt(4);
        o = sda_in;
        wt(4);
        scl_in = 1'b0;
        wt(4);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        wt(4);
        scl_in = 1'b1;
        wt(8);
        sda_drv = 1'b0;
        wt(8);
        scl_in = 1'b0;
        wt(4);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0;
        wt(4);
        scl_in = 1'b1;
        wt(8);
        sda_drv = 1'b1;
        wt(8);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic o;
        exp_val.push_back({7'b0, exp_ack});
        exp_name.push_back(name);
        for (int i = 7; i >= 0; i--) bit_slot(b[i], o);
        bit_slot(1'b1, o);
        obs_val.push_back({7'b0, o});
    endtask

    task automatic rd_byte(input logic [7:0] exp, input logic ack, input string name);
        logic [7:0] d;
        logic       o;
        exp_val.push_back(exp);
        exp_name.push_back(name);
        for (int i = 7; i >= 0; i--) begin
            bit_slot(1'b1, o);
            d[i] = o;
        end
        bit_slot(ack, o);
        obs_val.push_back(d);
    endtask

    task automatic exp_wr(input logic [2:0] idx, input logic [7:0] data);
        exp_wr_idx.push_back(idx);
        exp_wr_data.push_back(data);
    endtask

    // Bus observation checker: pairs each observed ACK/read byte with its expectation.
    initial begin
        logic [7:0] o;
        forever begin
            @(negedge PCLK);
            while (obs_val.size() > 0) begin
                o = obs_val.pop_front();
                if (exp_val.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_obs: got %02h expected none", o);
                end else begin
                    check(exp_name.pop_front(), o, exp_val.pop_front());
                end
            end
        end
    end

    // Bank write monitor: every wr_stb must match the next queued write.
    initial begin
        logic [2:0] idx;
        logic [7:0] d;
        forever begin
            @(negedge PCLK);
            if (PRESETn && wr_stb) begin
                if (exp_wr_idx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_wr_stb: got idx %0d expected no write", wr_idx);
                end else begin
                    idx = exp_wr_idx.pop_front();
                    d   = exp_wr_data.pop_front();
                    check("wr_idx", 8'(wr_idx), 8'(idx));
                    check("wr_data", dut.bank[idx], d);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wt(3);
        check("rst_sda_out", 8'(sda_out), 8'h01);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_wr_stb", 8'(wr_stb), 8'h00);
        check("rst_wr_idx", 8'(wr_idx), 8'h00);
        for (int i = 0; i < 8; i++) begin
            loc_addr = 3'(i);
            #1;
            check($sformatf("rst_bank%0d", i), loc_rdata, 8'h00);
        end
        PRESETn = 1'b1;
        wt(4);

        // Write with pointer wrap: bank[5..7], bank[0]
        i2c_start();
        wr_byte(8'hA0, 1'b0, "prep_addr_ack");
        wr_byte(8'h05, 1'b0, "prep_ptr_ack");
        exp_wr(3'd5, 8'h55);
        wr_byte(8'h55, 1'b0, "prep_d5_ack");
        exp_wr(3'd6, 8'h66);
        wr_byte(8'h66, 1'b0, "prep_d6_ack");
        exp_wr(3'd7, 8'h77);
        wr_byte(8'h77, 1'b0, "prep_d7_ack");
        exp_wr(3'd0, 8'h88);
        wr_byte(8'h88, 1'b0, "prep_d0_ack");
        i2c_stop();

        // Basic write
        i2c_start();
        wr_byte(8'hA0, 1'b0, "wr_addr_ack");
        check("wr_busy", 8'(busy), 8'h01);
        wr_byte(8'h02, 1'b0, "wr_ptr_ack");
        exp_wr(3'd2, 8'h11);
        wr_byte(8'h11, 1'b0, "wr_d2_ack");
        exp_wr(3'd3, 8'h22);
        wr_byte(8'h22, 1'b0, "wr_d3_ack");
        i2c_stop();
        check("wr_busy_after_stop", 8'(busy), 8'h00);
        loc_addr = 3'd3;
        #1;
        check("loc_rdata3", loc_rdata, 8'h22);
        loc_addr = 3'd2;
        #1;
        check("loc_rdata2", loc_rdata, 8'h11);

        // Read with repeated START, wrapping 7 -> 0
        i2c_start();
        wr_byte(8'hA0, 1'b0, "rd_waddr_ack");
        wr_byte(8'h06, 1'b0, "rd_ptr_ack");
        i2c_start();
        wr_byte(8'hA1, 1'b0, "rd_raddr_ack");
        rd_byte(8'h66, 1'b0, "rd_b6");
        rd_byte(8'h77, 1'b0, "rd_b7");
        rd_byte(8'h88, 1'b1, "rd_b0_wrap");
        check("rd_sda_released", 8'(sda_out), 8'h01);
        check("rd_busy_after_nack", 8'(busy), 8'h00);
        i2c_stop();
        check("rd_busy_after_stop", 8'(busy), 8'h00);

        // Address mismatch, then a START that must still be honoured
        i2c_start();
        wr_byte(8'hB0, 1'b1, "mis_no_ack");
        check("mis_busy", 8'(busy), 8'h00);
        i2c_start();
        wr_byte(8'hA0, 1'b0, "mis_next_ack");
        wr_byte(8'h04, 1'b0, "stopmid_ptr_ack");

        // STOP after 4 data bits: nothing written to bank[4]
        begin
            logic o;
            for (int i = 0; i < 4; i++) bit_slot(1'b1, o);
        end
        i2c_stop();
        check("stopmid_sda_out", 8'(sda_out), 8'h01);
        check("stopmid_busy", 8'(busy), 8'h00);
        loc_addr = 3'd4;
        #1;
        check("stopmid_bank4", loc_rdata, 8'h00);

        // Pointer-only write then single-byte read
        i2c_start();
        wr_byte(8'hA0, 1'b0, "ptronly_addr_ack");
        wr_byte(8'h05, 1'b0, "ptronly_ptr_ack");
        i2c_stop();
        i2c_start();
        wr_byte(8'hA1, 1'b0, "ptronly_raddr_ack");
        rd_byte(8'h55, 1'b1, "ptronly_rd5");
        i2c_stop();

        // Reset while driving bit 7 of bank[6] (0x66 -> first bit 0)
        i2c_start();
        wr_byte(8'hA1, 1'b0, "rst_raddr_ack");
        check("rst_pre_drive_low", 8'(sda_out), 8'h00);
        PRESETn = 1'b0;
        #1;
        check("rst_async_sda_out", 8'(sda_out), 8'h01);
        check("rst_mid_busy", 8'(busy), 8'h00);
        check("rst_mid_ptr", 8'(dut.ptr), 8'h00);
        for (int i = 0; i < 8; i++) begin
            loc_addr = 3'(i);
            #1;
            check($sformatf("rst_mid_bank%0d", i), loc_rdata, 8'h00);
        end
        scl_in  = 1'b1;
        sda_drv = 1'b1;
        wt(4);
        PRESETn = 1'b1;
        wt(8);

        // Block is usable again after reset
        i2c_start();
        wr_byte(8'hA0, 1'b0, "post_addr_ack");
        wr_byte(8'h01, 1'b0, "post_ptr_ack");
        exp_wr(3'd1, 8'h5A);
        wr_byte(8'h5A, 1'b0, "post_d1_ack");
        i2c_stop();
        loc_addr = 3'd1;
        #1;
        check("post_bank1", loc_rdata, 8'h5A);
        loc_addr = 3'd6;
        #1;
        check("post_bank6", loc_rdata, 8'h00);

        wt(20);
        check("obs_queue_drained", 8'(exp_val.size()), 8'h00);
        check("wr_queue_drained", 8'(exp_wr_idx.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
